// File: rtl/mrv32_fetch.sv
// mrv32 instruction fetch stage: owns the PC, issues in-order word reads to
// instruction memory and buffers {pc, instr} pairs for decode.
module mrv32_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = $clog2(DEPTH);
    localparam logic [CW:0]   LIMIT = CW1'(DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

    logic [31:0]   r_pc;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_occ;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_tag_wptr;
    logic [PW-1:0] r_tag_rptr;
    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [31:0]   r_tag        [DEPTH];

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_credit_used;
    logic          w_unused_pc_lsb;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        ptr_next = (p == LAST) ? {PW{1'b0}} : p + PW'(1'b1);
    endfunction

    // Credit covers both buffered entries and outstanding reads, so the FIFO never overflows.
    assign w_credit_used   = {1'b0, r_out_cnt} + {1'b0, r_occ};
    assign imem_req_valid  = !rst && !redirect_valid && (w_credit_used < LIMIT);
    assign imem_req_addr   = r_pc;
    assign w_accept        = imem_req_valid && imem_req_ready;
    assign w_push          = imem_rsp_valid && !redirect_valid && (r_drop_cnt == {CW{1'b0}});
    assign w_pop           = if_valid && if_ready;
    assign if_valid        = (r_occ != {CW{1'b0}});
    assign if_instr        = r_fifo_instr[r_rptr];
    assign if_pc           = r_fifo_pc[r_rptr];
    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    // Control state: PC, outstanding/drop counters, FIFO and tag-queue pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_out_cnt  <= {CW{1'b0}};
            r_drop_cnt <= {CW{1'b0}};
            r_occ      <= {CW{1'b0}};
            r_wptr     <= {PW{1'b0}};
            r_rptr     <= {PW{1'b0}};
            r_tag_wptr <= {PW{1'b0}};
            r_tag_rptr <= {PW{1'b0}};
        end else if (redirect_valid) begin
            // Everything still in flight (minus a response landing now) becomes a drop.
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_out_cnt  <= r_out_cnt - CW'(imem_rsp_valid);
            r_drop_cnt <= r_out_cnt - CW'(imem_rsp_valid);
            r_occ      <= {CW{1'b0}};
            r_wptr     <= {PW{1'b0}};
            r_rptr     <= {PW{1'b0}};
            r_tag_wptr <= {PW{1'b0}};
            r_tag_rptr <= {PW{1'b0}};
        end else begin
            r_out_cnt <= r_out_cnt + CW'(w_accept) - CW'(imem_rsp_valid);
            r_occ     <= r_occ + CW'(w_push) - CW'(w_pop);
            if (w_accept) begin
                r_pc       <= r_pc + 32'd4;
                r_tag_wptr <= ptr_next(r_tag_wptr);
            end
            if (imem_rsp_valid && (r_drop_cnt != {CW{1'b0}})) begin
                r_drop_cnt <= r_drop_cnt - CW'(1'b1);
            end
            if (w_push) begin
                r_wptr     <= ptr_next(r_wptr);
                r_tag_rptr <= ptr_next(r_tag_rptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
        end
    end

    // Payload storage: request PC tags and buffered {pc, instr}; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag[r_tag_wptr] <= r_pc;
        end
        if (w_push) begin
            r_fifo_pc[r_wptr]    <= r_tag[r_tag_rptr];
            r_fifo_instr[r_wptr] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_mrv32_fetch.sv
// Randomized scoreboard bench for mrv32_fetch: a memory model with variable
// latency, a stream-level reference of expected {pc, instr} and a decoupled monitor.
module tb_mrv32_fetch;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 3;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    mrv32_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pop = 0;
    int          cyc   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] stream_pc;
    logic [31:0] req_exp;
    logic [31:0] redir_tgt;
    bit          redir_prev = 1'b0;
    bit          rst_prev   = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C ^ (a * 32'd7);
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // The fetch stream is simply consecutive words from its start address.
    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back({stream_pc, mem_fn(stream_pc)});
            stream_pc = stream_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] p);
        exp_q.delete();
        stream_pc = p;
        req_exp   = p;
        refill();
    endtask

    task automatic step(input bit rst_v, input bit rdy, input int lat_max,
                        input bit ifr, input bit redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_v;
        if (rst_v) begin
            pend_addr.delete();
            pend_due.delete();
            exp_q.delete();
        end else if (rst_prev) begin
            restart(RST_PC);
        end else if (redir_prev) begin
            restart(redir_tgt);
        end
        imem_req_ready = rdy;
        if_ready       = ifr;
        redirect_valid = redir && !rst_v;
        redirect_pc    = rpc;
        if (!rst_v && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_fn(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        if (rst_v) begin
            check(!if_valid, "rst_if_valid", {31'b0, if_valid}, 32'd0);
            check(!imem_req_valid, "rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        end else begin
            if (rst_prev)
                check(imem_req_valid && imem_req_addr == RST_PC, "first_req", imem_req_addr, RST_PC);
            if (redirect_valid)
                check(!imem_req_valid, "req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
            else if (imem_req_valid)
                check(imem_req_addr == req_exp, "req_addr", imem_req_addr, req_exp);
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + int'($urandom_range(1, lat_max)));
                req_exp = req_exp + 32'd4;
            end
            refill();
        end
        redir_prev = redirect_valid;
        redir_tgt  = {rpc[31:2], 2'b00};
        rst_prev   = rst_v;
    endtask

    // Monitor: every decode handshake must match the head of the expected stream.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && if_valid && if_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_output", if_pc, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(if_pc == e[63:32], "if_pc", if_pc, e[63:32]);
                    check(if_instr == e[31:0], "if_instr", if_instr, e[31:0]);
                end
            end
        end
    end

    initial begin
        int vcnt;
        logic [31:0] tgt;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if_ready       = 1'b0;
        repeat (3) step(1'b1, 1'b0, 1, 1'b0, 1'b0, 32'd0);

        // Streaming at full rate with 1-cycle memory, including the address wrap.
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b1, 1, 1'b1, 1'b0, 32'd0);
            if (i >= 5 && if_valid) vcnt++;
        end
        check(vcnt == 25, "throughput", vcnt, 32'd25);

        // Decode stall fills the FIFO and halts requests.
        repeat (10) step(1'b0, 1'b1, 1, 1'b0, 1'b0, 32'd0);
        check(if_valid && !imem_req_valid, "stall_full", {30'b0, if_valid, imem_req_valid}, 32'd2);
        repeat (10) step(1'b0, 1'b1, 1, 1'b1, 1'b0, 32'd0);

        // Back-pressured requests with 3-cycle memory.
        for (int i = 0; i < 30; i++) step(1'b0, (i % 2) == 0, 3, 1'b1, 1'b0, 32'd0);

        // Redirect with reads in flight.
        repeat (5) step(1'b0, 1'b1, 3, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 3, 1'b1, 1'b1, 32'h0000_0100);
        repeat (12) step(1'b0, 1'b1, 3, 1'b1, 1'b0, 32'd0);

        // Redirect coinciding with a response and a pop.
        repeat (6) step(1'b0, 1'b1, 1, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1, 1'b1, 1'b1, 32'h0000_0203);
        check(if_valid && imem_rsp_valid, "redir_pop_rsp", {30'b0, if_valid, imem_rsp_valid}, 32'd3);
        repeat (10) step(1'b0, 1'b1, 1, 1'b1, 1'b0, 32'd0);

        // Mid-stream reset.
        repeat (2) step(1'b1, 1'b1, 1, 1'b1, 1'b0, 32'd0);
        repeat (10) step(1'b0, 1'b1, 1, 1'b1, 1'b0, 32'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                repeat (2) step(1'b1, 1'b1, 1, 1'b1, 1'b0, 32'd0);
            end else begin
                tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
                step(1'b0, $urandom_range(0, 3) != 0, 4, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 24) == 0, tgt);
            end
        end
        repeat (20) step(1'b0, 1'b1, 1, 1'b1, 1'b0, 32'd0);
        check(n_pop > 400, "progress", n_pop, 32'd400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
